// File: rtl/infix_to_postfix_stream_if.sv
// Token stream bundle for the infix-to-postfix converter: input token channel and
// postfix output channel, each with valid/ready flow control.
interface infix_to_postfix_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/infix_to_postfix_stream.sv
// Streaming shunting-yard converter: infix tokens in, postfix tokens out, one
// operator-stack pop/emit per cycle, sticky overflow and parenthesis errors.
module infix_to_postfix_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  infix_to_postfix_stream_if.slave   bus,
  output logic                       done,
  output logic                       err_overflow,
  output logic                       err_paren,
  output logic [PTR_W-1:0]           depth
);
  localparam int AW = PTR_W - 1;

  localparam logic [WIDTH-1:0] T_ADD = WIDTH'(8'h2B);
  localparam logic [WIDTH-1:0] T_SUB = WIDTH'(8'h2D);
  localparam logic [WIDTH-1:0] T_MUL = WIDTH'(8'h2A);
  localparam logic [WIDTH-1:0] T_DIV = WIDTH'(8'h2F);
  localparam logic [WIDTH-1:0] T_LP  = WIDTH'(8'h28);
  localparam logic [WIDTH-1:0] T_RP  = WIDTH'(8'h29);
  localparam logic [WIDTH-1:0] T_EQ  = WIDTH'(8'h3D);

  typedef enum logic [2:0] {ACCEPT, POP_OP, POP_PAREN, FLUSH, EMIT_EQ} state_t;

  // Zero means "not a binary operator", so '(' never outranks an incoming operator.
  function automatic logic [1:0] prec(input logic [WIDTH-1:0] t);
    logic [1:0] p;
    p = 2'd0;
    if (t == T_ADD || t == T_SUB) p = 2'd1;
    else if (t == T_MUL || t == T_DIV) p = 2'd2;
    return p;
  endfunction

  state_t             state, state_n;
  logic [WIDTH-1:0]   stk [DEPTH];
  logic [PTR_W-1:0]   cnt;
  logic [PTR_W-1:0]   cnt_m1;
  logic [WIDTH-1:0]   top;
  logic [WIDTH-1:0]   held;
  logic               ov, oeq;
  logic [WIDTH-1:0]   od;
  logic               empty, full, out_load, take;
  logic               push, pop, emit, emit_eq, latch, set_par;
  logic [WIDTH-1:0]   push_val, emit_val;

  assign cnt_m1   = cnt - PTR_W'(1);
  assign top      = stk[cnt_m1[AW-1:0]];
  assign empty    = (cnt == '0);
  assign full     = (cnt == PTR_W'(DEPTH));
  assign out_load = !ov || bus.out_ready;

  assign bus.in_ready  = !rst && (state == ACCEPT) && out_load;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign take          = bus.in_valid && bus.in_ready;
  assign done          = ov && bus.out_ready && oeq;
  assign depth         = cnt;

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    pop      = 1'b0;
    emit     = 1'b0;
    emit_eq  = 1'b0;
    latch    = 1'b0;
    set_par  = 1'b0;
    push_val = bus.in_data;
    emit_val = top;
    unique case (state)
      ACCEPT: begin
        if (take) begin
          if (prec(bus.in_data) != 2'd0) begin
            if (empty || top == T_LP || prec(top) < prec(bus.in_data)) begin
              push = 1'b1;
            end else begin
              latch   = 1'b1;
              state_n = POP_OP;
            end
          end else if (bus.in_data == T_LP) begin
            push = 1'b1;
          end else if (bus.in_data == T_RP) begin
            state_n = POP_PAREN;
          end else if (bus.in_data == T_EQ) begin
            state_n = FLUSH;
          end else begin
            emit     = 1'b1;
            emit_val = bus.in_data;
          end
        end
      end
      POP_OP: begin
        if (!empty && top != T_LP && prec(top) >= prec(held)) begin
          pop  = out_load;
          emit = out_load;
        end else begin
          push     = 1'b1;
          push_val = held;
          state_n  = ACCEPT;
        end
      end
      POP_PAREN: begin
        if (empty) begin
          set_par = 1'b1;
          state_n = ACCEPT;
        end else if (top == T_LP) begin
          pop     = 1'b1;
          state_n = ACCEPT;
        end else begin
          pop  = out_load;
          emit = out_load;
        end
      end
      FLUSH: begin
        if (empty) begin
          state_n = EMIT_EQ;
        end else if (top == T_LP) begin
          // Unclosed '(' is discarded without touching the output register.
          pop     = 1'b1;
          set_par = 1'b1;
        end else begin
          pop  = out_load;
          emit = out_load;
        end
      end
      EMIT_EQ: begin
        if (out_load) begin
          emit     = 1'b1;
          emit_eq  = 1'b1;
          emit_val = T_EQ;
          state_n  = ACCEPT;
        end
      end
      default: state_n = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCEPT;
      cnt          <= '0;
      held         <= '0;
      ov           <= 1'b0;
      od           <= '0;
      oeq          <= 1'b0;
      err_overflow <= 1'b0;
      err_paren    <= 1'b0;
    end else begin
      state <= state_n;
      if (latch) held <= bus.in_data;
      if (push && !full) cnt <= cnt + PTR_W'(1);
      else if (pop) cnt <= cnt_m1;
      if (emit) begin
        ov  <= 1'b1;
        od  <= emit_val;
        oeq <= emit_eq;
      end else if (ov && bus.out_ready) begin
        ov <= 1'b0;
      end
      if (push && full) err_overflow <= 1'b1;
      if (set_par) err_paren <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) stk[cnt[AW-1:0]] <= push_val;
  end
endmodule

// File: tb/tb_infix_to_postfix_stream.sv
// Scoreboard bench: a queue-based shunting-yard model predicts the postfix stream,
// a negedge monitor compares every output transfer against it.
module tb_infix_to_postfix_stream;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH) + 1;

  localparam logic [7:0] ADD = 8'h2B;
  localparam logic [7:0] SUB = 8'h2D;
  localparam logic [7:0] MUL = 8'h2A;
  localparam logic [7:0] DIV = 8'h2F;
  localparam logic [7:0] LP  = 8'h28;
  localparam logic [7:0] RP  = 8'h29;
  localparam logic [7:0] EQ  = 8'h3D;
  localparam logic [7:0] TA  = 8'h61;
  localparam logic [7:0] TB  = 8'h62;
  localparam logic [7:0] TC  = 8'h63;
  localparam logic [7:0] TD  = 8'h64;

  typedef logic [7:0] tokq_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             done, err_overflow, err_paren;
  logic [PTR_W-1:0] depth;

  infix_to_postfix_stream_if #(.WIDTH(8)) bus ();

  infix_to_postfix_stream #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .done         (done),
    .err_overflow (err_overflow),
    .err_paren    (err_paren),
    .depth        (depth)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         rmode  = 0;
  logic [7:0] expq[$];
  logic [7:0] mstk[$];
  bit         m_ovf = 1'b0;
  bit         m_par = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int prec_of(input logic [7:0] t);
    if (t == ADD || t == SUB) return 1;
    if (t == MUL || t == DIV) return 2;
    return 0;
  endfunction

  task automatic mpush(input logic [7:0] t);
    if (mstk.size() < DEPTH) mstk.push_back(t);
    else m_ovf = 1'b1;
  endtask

  // Textbook shunting-yard over a bounded queue stack.
  task automatic model_step(input logic [7:0] t);
    logic [7:0] x;
    if (prec_of(t) != 0) begin
      while (mstk.size() > 0 && mstk[$] != LP && prec_of(mstk[$]) >= prec_of(t))
        expq.push_back(mstk.pop_back());
      mpush(t);
    end else if (t == LP) begin
      mpush(t);
    end else if (t == RP) begin
      while (mstk.size() > 0 && mstk[$] != LP) expq.push_back(mstk.pop_back());
      if (mstk.size() == 0) m_par = 1'b1;
      else x = mstk.pop_back();
    end else if (t == EQ) begin
      while (mstk.size() > 0) begin
        x = mstk.pop_back();
        if (x == LP) m_par = 1'b1;
        else expq.push_back(x);
      end
      expq.push_back(EQ);
    end else begin
      expq.push_back(t);
    end
  endtask

  // Output-side ready driver
  initial begin
    int ph;
    logic [3:0] pat;
    ph  = 0;
    pat = 4'b1001;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: begin bus.out_ready = pat[3 - (ph % 4)]; ph++; end
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold valid", bus.out_valid, 1);
        chk("hold data", bus.out_data, stall_data);
      end
      if (bus.out_valid && !bus.out_ready) chk("in_ready while stalled", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output: got %0h expected none", bus.out_data);
        end else begin
          e = expq.pop_front();
          chk("out_data", bus.out_data, e);
          chk("done on transfer", done, (e == EQ) ? 1 : 0);
        end
      end else begin
        chk("done idle", done, 0);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end
  end

  task automatic send(input logic [7:0] t);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = t;
    @(negedge clk);
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send timeout: in_ready got 0 expected 1 (token %0h)", t);
    end else begin
      model_step(t);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_seq(input tokq_t s);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((expq.size() != 0 || bus.out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s drain: got %0d pending expected 0", name, expq.size());
    end
    repeat (3) @(negedge clk);
    chk({name, " depth"}, 32'(depth), mstk.size());
    chk({name, " err_overflow"}, err_overflow, m_ovf);
    chk({name, " err_paren"}, err_paren, m_par);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expq.delete();
    mstk.delete();
    m_ovf = 1'b0;
    m_par = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tokq_t      s;
    logic [7:0] ops [4];
    logic [7:0] v;
    int         len, r;
    ops = '{ADD, SUB, MUL, DIV};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst depth", 32'(depth), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", bus.in_ready, 1);
    chk("post-rst out_data", bus.out_data, 0);
    chk("post-rst errors", {err_overflow, err_paren}, 0);
    @(posedge clk);
    #1;

    rmode = 0;
    s = '{TA, ADD, TB, MUL, TC, EQ};
    run_seq(s);
    drain("precedence");

    do_reset();
    s = '{TA, SUB, TB, SUB, TC, EQ};
    run_seq(s);
    drain("left assoc");
    s = '{LP, TA, ADD, TB, RP, MUL, TC, EQ};
    run_seq(s);
    drain("parens");

    rmode = 1;
    s = '{TA, MUL, TB, ADD, TC, EQ};
    run_seq(s);
    drain("backpressure");

    rmode = 0;
    do_reset();
    s = '{LP, LP, LP, LP, LP};
    run_seq(s);
    drain("overflow");
    chk("overflow depth full", 32'(depth), DEPTH);
    chk("overflow flag", err_overflow, 1);
    s = '{TA, RP, EQ};
    run_seq(s);
    drain("overflow sticky");
    chk("overflow still set", err_overflow, 1);

    do_reset();
    s = '{TA, RP, EQ};
    run_seq(s);
    drain("stray rparen");
    do_reset();
    s = '{LP, TA, EQ};
    run_seq(s);
    drain("unclosed lparen");

    // Reset while FLUSH is stalled on a full output register
    do_reset();
    s = '{TA, ADD, TB, MUL, TC};
    run_seq(s);
    drain("pre-flush");
    rmode = 3;
    @(posedge clk);
    #1;
    send(EQ);
    repeat (4) @(negedge clk);
    chk("flush stalled valid", bus.out_valid, 1);
    chk("flush stalled data", bus.out_data, MUL);
    chk("flush stalled depth", 32'(depth), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expq.delete();
    mstk.delete();
    m_ovf = 1'b0;
    m_par = 1'b0;
    @(negedge clk);
    chk("mid rst in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst out_valid", bus.out_valid, 0);
    chk("mid rst depth", 32'(depth), 0);
    chk("mid rst in_ready after", bus.in_ready, 1);
    rmode = 0;
    @(posedge clk);
    #1;
    s = '{TD, EQ};
    run_seq(s);
    drain("after mid rst");

    // Random token streams, possibly malformed
    do_reset();
    for (int e = 0; e < 40; e++) begin
      rmode = $urandom_range(0, 2);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 99);
        if (r < 40) begin
          v = 8'($urandom_range(0, 255));
          if (prec_of(v) != 0 || v == LP || v == RP || v == EQ) v = 8'h78;
        end else if (r < 70) begin
          v = ops[$urandom_range(0, 3)];
        end else if (r < 85) begin
          v = LP;
        end else begin
          v = RP;
        end
        send(v);
      end
      send(EQ);
      drain("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/infix_to_postfix_stream.md
Name: infix_to_postfix_stream

Overview:
- Streaming shunting-yard converter: accepts infix expression tokens one per handshake and emits the equivalent postfix token stream for the stack-based ALU evaluator.
- Uses an internal operator stack of parametrised depth and supports four binary operators (+ - * /) with standard precedence and left associativity.
- Handles parentheses, the '=' terminator, valid/ready flow control on both sides, and sticky error reporting.

Parameters:
- WIDTH, 8, token width in bits; must be >= 8. Operator codes are ASCII, zero-extended to WIDTH.
- DEPTH, 16, operator stack entries; must be a power of 2, >= 2.
- PTR_W, $clog2(DEPTH)+1, stack pointer/count width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input token valid
- in_data  in  WIDTH  input token (ASCII operator/paren/'=' or operand)
- in_ready  out  1  block can accept a token this cycle
- out_valid  out  1  output token valid
- out_data  out  WIDTH  postfix token
- out_ready  in  1  downstream accepts out_data
- done  out  1  one-cycle pulse when the '=' token is transferred on the output
- err_overflow  out  1  sticky: push attempted with stack full
- err_paren  out  1  sticky: unmatched ')' or unclosed '(' at '='
- depth  out  PTR_W  current stack occupancy

Behaviour:
- Single clock domain (clk). rst is synchronous, active-high and has priority over all other activity.
- Reset values: in_ready=0 during rst and 1 in the first cycle after; out_valid=0, out_data=0, done=0, err_*=0, depth=0, FSM=ACCEPT.
- Token classes: '+','-' precedence 1; '*','/' precedence 2; '(' ; ')' ; '='; every other value is an operand.
- Output register: loads when !out_valid || out_ready. It holds out_data stable while out_valid && !out_ready.
- in_ready = (state==ACCEPT) && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready.
- FSM states:
  - ACCEPT: waits for an input token.
  - POP_OP: pops the stack while top precedence >= incoming precedence and top != '('. When the condition fails, pushes the held operator and returns to ACCEPT.
  - POP_PAREN: pops and emits until top=='('. Then discards '(' without emitting it and returns to ACCEPT.
  - FLUSH: pops and emits until the stack is empty, then goes to EMIT_EQ.
  - EMIT_EQ: emits '=', pulses done on that output transfer, and returns to ACCEPT.
- Operand in ACCEPT: goes straight to the output register; out_valid rises on the next cycle (latency 1). The stack is unchanged.
- Operator in ACCEPT:
  - If the stack is empty, top=='(', or top precedence < incoming precedence, push on the next edge and stay in ACCEPT. No output.
  - Otherwise latch the operator and enter POP_OP.
- '(' in ACCEPT: push; stay in ACCEPT.
- ')' in ACCEPT: enter POP_PAREN. If the stack empties before '(' is found, set err_paren, drop the ')', and return to ACCEPT.
- '=' in ACCEPT: enter FLUSH. Any '(' popped during FLUSH is not emitted and sets err_paren.
- Pop rate: at most one pop/emit per cycle, and only on cycles where the output register can load; otherwise the FSM stalls in place.
- Stack full on any push: the token is dropped, err_overflow is set, the stack is unchanged, and the FSM returns to ACCEPT.
- Errors are sticky until rst. Conversion continues after an error; output is then undefined semantically but the handshake stays legal.
- depth reflects the stack count after each edge. Push and pop never occur in the same cycle.
- rst mid-operation (any state): the stack is cleared, the pending output is discarded (out_valid=0 on the next cycle), and the FSM returns to ACCEPT.
- Operand range: no arithmetic is performed; operands are opaque WIDTH-bit values. Operands equal to an operator code are treated as operators.

Test Plan:
- Precedence: a + b * c = with out_ready=1 → outputs a b c * + = in order; done pulses with '='; depth returns to 0; no errors.
- Left associativity and parentheses: a - b - c = → a b - c - =; and ( a + b ) * c = → a b + c * =, with no '(' or ')' emitted.
- Backpressure: send a * b + c = with out_ready toggling 1,0,0,1,… → output sequence a b * c + = unchanged; out_data stable while stalled; in_ready=0 whenever out_valid && !out_ready.
- Overflow: DEPTH=4, send ( ( ( ( ( → fifth '(' dropped; err_overflow=1; depth=4; err_overflow stays 1 after further tokens until rst.
- Paren errors:
  - a ) = → err_paren=1; output a =.
  - ( a = → err_paren=1; output a =.
- Reset mid-flush: a + b * c ( stack holds 2 ops ), assert rst in FLUSH with out_ready=0 → next cycle out_valid=0, depth=0, in_ready=1 after rst deasserts; then d = → d =.
